cache_ctrl: RTL and testbench

//  Sequencer between CPU, 1024-line direct-mapped cache (4x32b words/line, 3b tag) and word-wide main memory.

---
 rtl/cache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencer between a CPU, a direct-mapped line cache and a
// word-wide main memory. Reads hit in the cache or fill a whole line from
// memory and look up again. Writes go straight through to memory. A write
// that hits refetches its line so the cache never holds stale data.
// Saturating hit/miss counters are kept for statistics.
module cache_ctrl #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_rd,
    input  logic                cpu_wr,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_done,
    input  logic                cache_hit,
    input  logic [WORD_W-1:0]   cache_rdata,
    output logic                cache_re,
    output logic                cache_we,
    output logic [ADDR_W-1:0]   cache_addr,
    output logic [4*WORD_W-1:0] cache_line,
    output logic                mem_re,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_WR,
        FILL,
        LINE_WR,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                isWr_q, isWr_d;
    logic [1:0]          k_q, k_d;
    logic [4*WORD_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]    hitCnt_q, hitCnt_d;
    logic [CNT_W-1:0]    missCnt_q, missCnt_d;
    logic                wrHit_q, wrHit_d;
    logic                wrHitVld_q, wrHitVld_d;
    logic                wrHitNow;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cache_addr = addr_q;
    assign cache_line = line_q;
    assign hit_cnt    = hitCnt_q;
    assign miss_cnt   = missCnt_q;

    // Next-state and output decode; the write-hit flag is frozen on the first MEM_WR cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        isWr_d     = isWr_q;
        k_d        = k_q;
        line_d     = line_q;
        hitCnt_d   = hitCnt_q;
        missCnt_d  = missCnt_q;
        wrHit_d    = wrHit_q;
        wrHitVld_d = wrHitVld_q;
        cpu_rdata  = '0;
        cpu_done   = 1'b0;
        cache_re   = 1'b0;
        cache_we   = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wrHitNow   = wrHitVld_q ? wrHit_q : cache_hit;

        case (state_q)
            IDLE: begin
                if (cpu_wr || cpu_rd) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    isWr_d     = cpu_wr;
                    rdata_d    = '0;
                    wrHitVld_d = 1'b0;
                    state_d    = cpu_wr ? MEM_WR : LOOKUP;
                end
            end
            LOOKUP: begin
                cache_re = 1'b1;
                if (cache_hit) begin
                    rdata_d  = cache_rdata;
                    hitCnt_d = satInc(hitCnt_q);
                    state_d  = DONE;
                end else begin
                    missCnt_d = satInc(missCnt_q);
                    k_d       = 2'd0;
                    state_d   = FILL;
                end
            end
            MEM_WR: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (!wrHitVld_q) begin
                    wrHit_d    = cache_hit;
                    wrHitVld_d = 1'b1;
                end
                if (mem_ready) begin
                    if (wrHitNow) begin
                        hitCnt_d = satInc(hitCnt_q);
                        k_d      = 2'd0;
                        state_d  = FILL;
                    end else begin
                        missCnt_d = satInc(missCnt_q);
                        state_d   = DONE;
                    end
                end
            end
            FILL: begin
                mem_re   = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], k_q};
                if (mem_ready) begin
                    for (int w = 0; w < 4; w++) begin
                        if (k_q == 2'(w)) begin
                            line_d[w*WORD_W +: WORD_W] = mem_rdata;
                        end
                    end
                    if (k_q == 2'd3) begin
                        state_d = LINE_WR;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            LINE_WR: begin
                cache_we = 1'b1;
                state_d  = isWr_q ? DONE : LOOKUP;
            end
            DONE: begin
                cpu_done  = 1'b1;
                cpu_rdata = rdata_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            isWr_q     <= 1'b0;
            k_q        <= 2'd0;
            line_q     <= '0;
            hitCnt_q   <= '0;
            missCnt_q  <= '0;
            wrHit_q    <= 1'b0;
            wrHitVld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            isWr_q     <= isWr_d;
            k_q        <= k_d;
            line_q     <= line_d;
            hitCnt_q   <= hitCnt_d;
            missCnt_q  <= missCnt_d;
            wrHit_q    <= wrHit_d;
            wrHitVld_q <= wrHitVld_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: drives directed and random CPU requests into cache_ctrl,
// emulates the external cache array and main memory, and compares every
// completed request with a request-level reference model.
module tb_cache_ctrl;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpuRd, cpuWr;
    logic [ADDR_W-1:0]   cpuAddr;
    logic [WORD_W-1:0]   cpuWdata, cpuRdata;
    logic                cpuDone;
    logic                cacheHit;
    logic [WORD_W-1:0]   cacheRdata;
    logic                cacheRe, cacheWe;
    logic [ADDR_W-1:0]   cacheAddr;
    logic [4*WORD_W-1:0] cacheLine;
    logic                memRe, memWe;
    logic [ADDR_W-1:0]   memAddr;
    logic [WORD_W-1:0]   memWdata, memRdata;
    logic                memReady;
    logic [CNT_W-1:0]    hitCnt, missCnt;

    cache_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpuRd), .cpu_wr(cpuWr), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdata), .cpu_done(cpuDone),
        .cache_hit(cacheHit), .cache_rdata(cacheRdata), .cache_re(cacheRe),
        .cache_we(cacheWe), .cache_addr(cacheAddr), .cache_line(cacheLine),
        .mem_re(memRe), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .mem_ready(memReady),
        .hit_cnt(hitCnt), .miss_cnt(missCnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Environment: memory and cache array seen by the DUT.
    logic [WORD_W-1:0] envMem   [0:32767];
    logic              envValid [0:1023];
    logic [2:0]        envTag   [0:1023];
    logic [WORD_W-1:0] envData  [0:1023][0:3];

    // Reference model state.
    logic [WORD_W-1:0] refMem   [0:32767];
    logic              refValid [0:1023];
    logic [2:0]        refTag   [0:1023];
    int                expHit;
    int                expMiss;

    // Observation logs filled by the environment.
    int                memRdLog [$];
    int                memWrCount;
    int                cacheWeCount;
    int                violations;
    logic [4*WORD_W-1:0] lastLine;
    logic [ADDR_W-1:0] lastWrAddr;
    logic [WORD_W-1:0] lastWrData;
    int                memLat;
    int                memWait;

    int checkCount = 0;
    int errorCount = 0;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Memory and cache-array responder, acting on the falling edge.
    initial begin : envProc
        logic [9:0] idx;
        memReady   = 1'b0;
        memRdata   = '0;
        cacheHit   = 1'b0;
        cacheRdata = '0;
        memWait    = -1;
        forever begin
            @(negedge clk);
            memReady = 1'b0;
            if (rst) begin
                memWait = -1;
            end else begin
                if (memRe && memWe) violations++;
                if (cacheWe && (memRe || memWe)) violations++;
                if (cacheWe) begin
                    idx = cacheAddr[11:2];
                    envValid[idx] = 1'b1;
                    envTag[idx]   = cacheAddr[14:12];
                    for (int w = 0; w < 4; w++) envData[idx][w] = cacheLine[w*WORD_W +: WORD_W];
                    cacheWeCount++;
                    lastLine = cacheLine;
                end
                if (memRe || memWe) begin
                    if (memWait < 0) memWait = (memLat >= 0) ? memLat : int'($urandom_range(0, 3));
                    if (memWait == 0) begin
                        memReady = 1'b1;
                        if (memWe) begin
                            envMem[memAddr] = memWdata;
                            memWrCount++;
                            lastWrAddr = memAddr;
                            lastWrData = memWdata;
                        end else begin
                            memRdata = envMem[memAddr];
                            memRdLog.push_back(int'(memAddr));
                        end
                        memWait = -1;
                    end else begin
                        memWait--;
                    end
                end else begin
                    memWait = -1;
                    if ($urandom_range(0, 7) == 0) begin
                        memReady = 1'b1;
                        memRdata = $urandom;
                    end
                end
            end
            idx = cacheAddr[11:2];
            cacheHit   = envValid[idx] && (envTag[idx] == cacheAddr[14:12]);
            cacheRdata = envData[idx][cacheAddr[1:0]];
        end
    end

    // Issue one request, predict its outcome from the model, and compare.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                                 input logic [WORD_W-1:0] data);
        logic [9:0]          idx;
        logic [2:0]          tag;
        bit                  wasHit;
        bit                  gotDone;
        int                  expRd, expWr, expWe, cycles, base;
        logic [WORD_W-1:0]   expData, gotData;
        logic [4*WORD_W-1:0] expLine;

        idx    = addr[11:2];
        tag    = addr[14:12];
        base   = int'({addr[14:2], 2'b00});
        wasHit = refValid[idx] && (refTag[idx] == tag);
        if (wr) begin
            refMem[addr] = data;
            expWr   = 1;
            expData = '0;
            if (wasHit) begin
                if (expHit < 65535) expHit++;
                expRd = 4; expWe = 1;
            end else begin
                if (expMiss < 65535) expMiss++;
                expRd = 0; expWe = 0;
            end
        end else begin
            expWr   = 0;
            expData = refMem[addr];
            if (wasHit) begin
                if (expHit < 65535) expHit++;
                expRd = 0; expWe = 0;
            end else begin
                if (expMiss < 65535) expMiss++;
                if (expHit < 65535) expHit++;
                expRd = 4; expWe = 1;
                refValid[idx] = 1'b1;
                refTag[idx]   = tag;
            end
        end
        for (int w = 0; w < 4; w++) expLine[w*WORD_W +: WORD_W] = refMem[base + w];

        @(negedge clk);
        memRdLog.delete();
        memWrCount   = 0;
        cacheWeCount = 0;
        violations   = 0;
        cpuRd    = rd;
        cpuWr    = wr;
        cpuAddr  = addr;
        cpuWdata = data;

        gotDone = 1'b0;
        gotData = '0;
        cycles  = 0;
        while (!gotDone && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cpuDone) begin
                gotDone = 1'b1;
                gotData = cpuRdata;
            end else if (cycles == 1) begin
                cpuAddr  = ADDR_W'($urandom);
                cpuWdata = $urandom;
            end
        end
        cpuRd = 1'b0;
        cpuWr = 1'b0;

        checkOutput("doneSeen", 128'(gotDone), 128'(1));
        checkOutput("rdata", 128'(gotData), 128'(expData));
        checkOutput("hitCnt", 128'(hitCnt), 128'(expHit));
        checkOutput("missCnt", 128'(missCnt), 128'(expMiss));
        checkOutput("memRdCount", 128'(memRdLog.size()), 128'(expRd));
        for (int i = 0; i < memRdLog.size() && i < expRd; i++)
            checkOutput("fillAddr", 128'(memRdLog[i]), 128'(base + i));
        checkOutput("memWrCount", 128'(memWrCount), 128'(expWr));
        checkOutput("cacheWeCount", 128'(cacheWeCount), 128'(expWe));
        checkOutput("exclusive", 128'(violations), 128'(0));
        if (expWr == 1) begin
            checkOutput("wrAddr", 128'(lastWrAddr), 128'(addr));
            checkOutput("wrData", 128'(lastWrData), 128'(data));
        end
        if (expWe == 1) checkOutput("fillLine", lastLine, expLine);
        if (!wr && wasHit) checkOutput("hitLatency", 128'(cycles), 128'(2));

        @(posedge clk);
        #1;
        checkOutput("doneOnce", 128'(cpuDone), 128'(0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin : mainProc
        logic [ADDR_W-1:0] a;
        int n;
        int op;
        logic [9:0] idxPool [4];
        idxPool[0] = 10'd5; idxPool[1] = 10'h123; idxPool[2] = 10'h3FF; idxPool[3] = 10'h010;

        rst = 1'b1;
        cpuRd = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWdata = '0;
        memLat = -1; expHit = 0; expMiss = 0;
        memWrCount = 0; cacheWeCount = 0; violations = 0;
        lastLine = '0; lastWrAddr = '0; lastWrData = '0;
        for (int i = 0; i < 32768; i++) begin
            envMem[i] = $urandom;
            refMem[i] = envMem[i];
        end
        for (int i = 0; i < 1024; i++) begin
            envValid[i] = 1'b0; envTag[i] = '0; refValid[i] = 1'b0; refTag[i] = '0;
            for (int w = 0; w < 4; w++) envData[i][w] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstCtl", 128'({cpuDone, cacheRe, cacheWe, memRe, memWe}), 128'(0));
        checkOutput("rstCnt", 128'({hitCnt, missCnt}), 128'(0));
        checkOutput("rstLine", cacheLine, 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Preload idx5 tag2 by a fill, then read word 1 as a hit.
        applyStimulus(1'b1, 1'b0, {3'd2, 10'd5, 2'd1}, '0);
        applyStimulus(1'b1, 1'b0, {3'd2, 10'd5, 2'd1}, '0);

        // Cold read with a fixed 3-cycle memory latency and known words.
        for (int w = 0; w < 4; w++) begin
            envMem[15'h1234 + w] = 32'hA0 + w;
            refMem[15'h1234 + w] = 32'hA0 + w;
        end
        memLat = 3;
        applyStimulus(1'b1, 1'b0, 15'h1234, '0);
        memLat = -1;

        // Write miss, then write hit with refill and a read of the new data.
        applyStimulus(1'b0, 1'b1, 15'h0040, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 15'h1235, 32'hCAFE0123);
        applyStimulus(1'b1, 1'b0, 15'h1235, '0);

        // Reset in the middle of a fill, then the same read refills from word 0.
        @(negedge clk);
        memRdLog.delete();
        cpuRd = 1'b1; cpuAddr = 15'h2468;
        n = 0;
        while (memRdLog.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fillProgress", 128'(memRdLog.size()), 128'(2));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstCtl", 128'({cpuDone, cacheRe, cacheWe, memRe, memWe}), 128'(0));
        checkOutput("midRstAddr", 128'({cacheAddr, memAddr, memWdata}), 128'(0));
        checkOutput("midRstData", 128'({cpuRdata, hitCnt, missCnt}), 128'(0));
        checkOutput("midRstLine", cacheLine, 128'(0));
        cpuRd = 1'b0;
        expHit = 0; expMiss = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 15'h2468, '0);

        // Read and write together behave as a write; miss counter saturation.
        applyStimulus(1'b1, 1'b1, 15'h0500, 32'h12345678);
        @(negedge clk);
        force dut.missCnt_q = 16'hFFFF;
        #1;
        release dut.missCnt_q;
        expMiss = 65535;
        #1;
        checkOutput("missForced", 128'(missCnt), 128'(16'hFFFF));
        applyStimulus(1'b0, 1'b1, 15'h0704, 32'h0BADF00D);

        // Randomized traffic over a few indices to mix hits and misses.
        for (int r = 0; r < 150; r++) begin
            a  = {3'($urandom_range(0, 7)), idxPool[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
            op = int'($urandom_range(0, 3));
            if (op == 0)      applyStimulus(1'b0, 1'b1, a, $urandom);
            else if (op == 1) applyStimulus(1'b1, 1'b1, a, $urandom);
            else              applyStimulus(1'b1, 1'b0, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
